execute_memory_pipe: RTL and testbench

- Pipeline register between the execution unit and the data-memory stage.
- Captures the ALU/MULT result, store data, destination register and memory/writeback controls from execute, and presents them registered to memory.
- Handles downstream stalls, flushes and bubble insertion while the multiplier is busy.
- Holds a one-entry skid buffer so a single-cycle MULT_ready result arriving during a memory stall is never lost.

---
 rtl/execute_memory_pipe_pkg.sv | 26 ++
 rtl/pipe_skid_entry.sv | 32 +++
 rtl/execute_memory_pipe.sv | 153 +++++++++++++++
 tb/tb_execute_memory_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/execute_memory_pipe_pkg.sv
// Shared types for the execute->memory pipeline register: skid state encoding,
// control bundle layout and the bubble control value.
package execute_memory_pipe_pkg;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    localparam int unsigned CTRL_WIDTH = $bits(ctrl_t);

    localparam ctrl_t CTRL_BUBBLE = '{
        rd:        5'd0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0
    };

endpackage

// File: rtl/pipe_skid_entry.sv
// One registered payload slot with a valid flag; clear wins over load.
// Used both as the skid buffer and as the memory-side output register.
module pipe_skid_entry #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/execute_memory_pipe.sv
// Execute->memory pipeline register with stall/flush handling, bubbles while
// the multiplier is busy, and a one-entry skid for MULT results seen under stall.
module execute_memory_pipe
    import execute_memory_pipe_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    ex_valid,
    input  logic                    ex_stall_ALU,
    input  logic                    ex_MULT_ready,
    input  logic [DATA_WIDTH-1:0]   ex_ALU_result,
    input  logic [DATA_WIDTH-1:0]   ex_store_data,
    input  logic [ADDRESS_BITS-1:0] ex_PC,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_regWrite,
    input  logic                    ex_memRead,
    input  logic                    ex_memWrite,
    output logic                    ex_hold,
    output logic                    mem_valid,
    output logic [DATA_WIDTH-1:0]   mem_ALU_result,
    output logic [DATA_WIDTH-1:0]   mem_store_data,
    output logic [ADDRESS_BITS-1:0] mem_PC,
    output logic [4:0]              mem_rd,
    output logic                    mem_regWrite,
    output logic                    mem_memRead,
    output logic                    mem_memWrite,
    input  logic                    report
);

    localparam int unsigned PW = 2 * DATA_WIDTH + ADDRESS_BITS + CTRL_WIDTH;

    ctrl_t          w_ex_ctrl;
    ctrl_t          w_mem_ctrl;
    logic [PW-1:0]  w_ex_payload;
    logic [PW-1:0]  w_bubble;
    logic [PW-1:0]  w_skid_data;
    logic [PW-1:0]  w_out_data;
    logic [PW-1:0]  w_out_q;
    logic           w_skid_valid;
    logic           w_out_valid;
    logic           w_ex_fire;
    logic           w_skid_capture;
    logic           w_skid_load;
    logic           w_skid_clear;
    skid_state_e    r_skid_state;
    skid_state_e    w_skid_next;
    logic [31:0]    r_cycle;

    assign w_ex_ctrl = '{
        rd:        ex_rd,
        reg_write: ex_regWrite,
        mem_read:  ex_memRead,
        mem_write: ex_memWrite
    };
    assign w_ex_payload = {ex_ALU_result, ex_store_data, ex_PC, w_ex_ctrl};
    assign w_bubble     = {{(PW - CTRL_WIDTH){1'b0}}, CTRL_BUBBLE};

    // MULT_ready marks the final multiplier cycle, so it overrides stall_ALU.
    assign w_ex_fire      = ex_valid && (!ex_stall_ALU || ex_MULT_ready);
    assign w_skid_capture = stall && !flush && ex_valid && ex_MULT_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_skid_state <= SKID_EMPTY;
        end else begin
            r_skid_state <= w_skid_next;
        end
    end

    always_comb begin
        w_skid_next = r_skid_state;
        unique case (r_skid_state)
            SKID_EMPTY: if (w_skid_capture) w_skid_next = SKID_FULL;
            SKID_FULL:  if (flush || !stall) w_skid_next = SKID_EMPTY;
            default:    w_skid_next = SKID_EMPTY;
        endcase
    end

    always_comb begin
        w_skid_load  = (r_skid_state == SKID_EMPTY) && w_skid_capture;
        w_skid_clear = (r_skid_state == SKID_FULL) && (flush || !stall);
        ex_hold      = stall || (r_skid_state == SKID_FULL);
    end

    pipe_skid_entry #(
        .WIDTH (PW)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_valid (1'b1),
        .i_data  (w_ex_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    always_comb begin
        w_out_valid = 1'b0;
        w_out_data  = w_bubble;
        if (r_skid_state == SKID_FULL) begin
            w_out_valid = w_skid_valid;
            w_out_data  = w_skid_data;
        end else if (w_ex_fire) begin
            w_out_valid = 1'b1;
            w_out_data  = w_ex_payload;
        end
    end

    pipe_skid_entry #(
        .WIDTH (PW)
    ) u_out (
        .clock   (clock),
        .reset   (reset),
        .i_load  (!stall),
        .i_clear (flush),
        .i_valid (w_out_valid),
        .i_data  (w_out_data),
        .o_valid (mem_valid),
        .o_data  (w_out_q)
    );

    assign {mem_ALU_result, mem_store_data, mem_PC, w_mem_ctrl} = w_out_q;
    assign mem_rd       = w_mem_ctrl.rd;
    assign mem_regWrite = w_mem_ctrl.reg_write;
    assign mem_memRead  = w_mem_ctrl.mem_read;
    assign mem_memWrite = w_mem_ctrl.mem_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (report) begin
            $display("core %0d cycle %0d skid %s valid=%b res=%h sd=%h pc=%h rd=%0d rw=%b mr=%b mw=%b",
                     CORE, r_cycle, r_skid_state.name(), mem_valid, mem_ALU_result,
                     mem_store_data, mem_PC, mem_rd, mem_regWrite, mem_memRead, mem_memWrite);
        end
    end
`endif

endmodule

// File: tb/tb_execute_memory_pipe.sv
// Randomized and directed bench for execute_memory_pipe against a rule-level
// model of the memory-side registers and the skid slot.
module tb_execute_memory_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [31:0] sd;
        logic [19:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } pl_t;

    logic        clock = 1'b0;
    logic        reset, stall, flush, report;
    logic        ex_valid, ex_stall_ALU, ex_MULT_ready;
    logic [31:0] ex_ALU_result, ex_store_data;
    logic [19:0] ex_PC;
    logic [4:0]  ex_rd;
    logic        ex_regWrite, ex_memRead, ex_memWrite;
    logic        ex_hold, mem_valid;
    logic [31:0] mem_ALU_result, mem_store_data;
    logic [19:0] mem_PC;
    logic [4:0]  mem_rd;
    logic        mem_regWrite, mem_memRead, mem_memWrite;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what memory currently sees, and the parked MULT result.
    pl_t  m_out;
    pl_t  m_skid;
    logic m_skid_full;

    always #5 clock = ~clock;

    execute_memory_pipe #(
        .CORE         (0),
        .DATA_WIDTH   (32),
        .ADDRESS_BITS (20)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_stall_ALU   (ex_stall_ALU),
        .ex_MULT_ready  (ex_MULT_ready),
        .ex_ALU_result  (ex_ALU_result),
        .ex_store_data  (ex_store_data),
        .ex_PC          (ex_PC),
        .ex_rd          (ex_rd),
        .ex_regWrite    (ex_regWrite),
        .ex_memRead     (ex_memRead),
        .ex_memWrite    (ex_memWrite),
        .ex_hold        (ex_hold),
        .mem_valid      (mem_valid),
        .mem_ALU_result (mem_ALU_result),
        .mem_store_data (mem_store_data),
        .mem_PC         (mem_PC),
        .mem_rd         (mem_rd),
        .mem_regWrite   (mem_regWrite),
        .mem_memRead    (mem_memRead),
        .mem_memWrite   (mem_memWrite),
        .report         (report)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] res, input logic [31:0] sd,
                          input logic [19:0] pc, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
        ex_valid      = v;
        ex_ALU_result = res;
        ex_store_data = sd;
        ex_PC         = pc;
        ex_rd         = rd;
        ex_regWrite   = rw;
        ex_memRead    = mr;
        ex_memWrite   = mw;
    endtask

    // Apply one clock with the current inputs, advance the model, compare everything.
    task automatic step();
        pl_t  ex;
        logic available;
        ex        = '{valid: 1'b1, res: ex_ALU_result, sd: ex_store_data, pc: ex_PC,
                      rd: ex_rd, rw: ex_regWrite, mr: ex_memRead, mw: ex_memWrite};
        available = ex_valid && (ex_MULT_ready || !ex_stall_ALU);
        if (reset || flush) begin
            m_out       = '0;
            m_skid_full = 1'b0;
        end else if (stall) begin
            if (!m_skid_full && ex_valid && ex_MULT_ready) begin
                m_skid      = ex;
                m_skid_full = 1'b1;
            end
        end else if (m_skid_full) begin
            m_out       = m_skid;
            m_skid_full = 1'b0;
        end else if (available) begin
            m_out = ex;
        end else begin
            m_out = '0;
        end
        @(posedge clock);
        #1;
        check("mem_valid",      64'(mem_valid),      64'(m_out.valid));
        check("mem_ALU_result", 64'(mem_ALU_result), 64'(m_out.res));
        check("mem_store_data", 64'(mem_store_data), 64'(m_out.sd));
        check("mem_PC",         64'(mem_PC),         64'(m_out.pc));
        check("mem_rd",         64'(mem_rd),         64'(m_out.rd));
        check("mem_regWrite",   64'(mem_regWrite),   64'(m_out.rw));
        check("mem_memRead",    64'(mem_memRead),    64'(m_out.mr));
        check("mem_memWrite",   64'(mem_memWrite),   64'(m_out.mw));
        check("ex_hold",        64'(ex_hold),        64'(stall | m_skid_full));
    endtask

    initial begin
        m_out       = '0;
        m_skid      = '0;
        m_skid_full = 1'b0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; report = 1'b0;
        ex_stall_ALU = 1'b0; ex_MULT_ready = 1'b0;
        set_ex(1'b0, 32'd0, 32'd0, 20'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("reset_valid", 64'(mem_valid), 64'd0);
        reset = 1'b0;

        // Plain ALU result.
        set_ex(1'b1, 32'h0000_1234, 32'h0, 20'h00100, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        check("normal_res", 64'(mem_ALU_result), 64'h1234);
        check("normal_rd",  64'(mem_rd),         64'd5);

        // Multiplier busy three cycles, then final cycle.
        set_ex(1'b1, 32'h0000_0F0F, 32'h0, 20'h00104, 5'd7, 1'b1, 1'b0, 1'b0);
        ex_stall_ALU = 1'b1;
        repeat (3) begin
            step();
            check("busy_valid", 64'(mem_valid), 64'd0);
        end
        ex_MULT_ready = 1'b1;
        step();
        check("mult_res", 64'(mem_ALU_result), 64'h0F0F);
        ex_MULT_ready = 1'b0; ex_stall_ALU = 1'b0;

        // MULT result arrives under stall and must be parked.
        stall = 1'b1; ex_stall_ALU = 1'b1; ex_MULT_ready = 1'b1;
        set_ex(1'b1, 32'hDEAD_BEEF, 32'h0, 20'h00108, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        check("skid_hold_res", 64'(mem_ALU_result), 64'h0F0F);
        check("skid_hold",     64'(ex_hold),        64'd1);
        ex_MULT_ready = 1'b0; ex_stall_ALU = 1'b0; ex_valid = 1'b0;
        step();
        stall = 1'b0;
        step();
        check("skid_drain_res",  64'(mem_ALU_result), 64'hDEAD_BEEF);
        check("skid_drain_hold", 64'(ex_hold),        64'd0);

        // Flush while the skid holds a result.
        set_ex(1'b1, 32'h0000_0055, 32'h0, 20'h0010C, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        stall = 1'b1; ex_stall_ALU = 1'b1; ex_MULT_ready = 1'b1;
        set_ex(1'b1, 32'hDEAD_BEEF, 32'h0, 20'h00110, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        ex_MULT_ready = 1'b0; ex_stall_ALU = 1'b0; ex_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        step();
        check("flush_valid", 64'(mem_valid), 64'd0);
        check("flush_hold",  64'(ex_hold),   64'd0);
        check("flush_res_zero", 64'(mem_ALU_result), 64'd0);

        // Store pass-through.
        set_ex(1'b1, 32'h0000_0100, 32'hCAFE_0001, 20'h00114, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("store_mw", 64'(mem_memWrite),   64'd1);
        check("store_sd", 64'(mem_store_data), 64'hCAFE_0001);

        // Reset during a stall with the skid occupied.
        stall = 1'b1; ex_stall_ALU = 1'b1; ex_MULT_ready = 1'b1;
        set_ex(1'b1, 32'h1111_2222, 32'h0, 20'h00118, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        ex_MULT_ready = 1'b0; reset = 1'b1;
        step();
        check("rst_mid_valid", 64'(mem_valid), 64'd0);
        check("rst_mid_hold",  64'(ex_hold),   64'd1);
        reset = 1'b0; stall = 1'b0; ex_stall_ALU = 1'b0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            flush         = ($urandom_range(0, 99) < 6);
            stall         = ($urandom_range(0, 99) < 35);
            ex_stall_ALU  = ($urandom_range(0, 99) < 30);
            ex_MULT_ready = ($urandom_range(0, 99) < 25);
            set_ex($urandom_range(0, 99) < 80, $urandom, $urandom, 20'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
